// File: rtl/sys_timer_tick_master.sv
// -----------------------------------------------------------------------------
// sys_timer_tick_master
//
// Avalon-MM initiator for the 16-bit system interval-timer slave (s1 port).
// It programs the timer period and starts it. It services the timer irq in
// hardware by clearing the status register and counting ticks. It also reads
// 32-bit counter snapshots on request. No CPU is involved.
//
// Parameters
//   PERIOD  timer load value, written as period_l / period_h
//   CONT    control.CONT bit written at start (1 = continuous, 0 = one-shot)
//   TICK_W  width of tick_count
//
// Ports
//   clk            clock
//   reset_n        asynchronous active-low reset
//   enable         level: 1 = configure and run the timer, 0 = stop it
//   snap_req       1-cycle pulse requesting a counter snapshot
//   tm_irq         timer irq level (held until status is cleared)
//   tm_address     timer register address
//   tm_chipselect  timer chipselect
//   tm_write_n     timer write strobe, active low
//   tm_writedata   timer write data
//   tm_readdata    timer read data, valid one cycle after the address
//   tick_count     number of serviced timeouts (wraps)
//   tick_pulse     1-cycle pulse per serviced timeout
//   snap_value     last snapshot {snaph, snapl}
//   snap_valid     1-cycle pulse when snap_value is updated
//   busy           high in every bus-transaction state (not IDLE/RUN)
//
// All outputs are registered. Bus outputs are computed from the next state,
// so the registered bus signals line up with the state register. Each FSM
// state therefore corresponds to exactly one bus cycle.
// -----------------------------------------------------------------------------
module sys_timer_tick_master #(
    parameter logic [31:0] PERIOD = 32'd49999,
    parameter bit          CONT   = 1'b1,
    parameter int          TICK_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              snap_req,
    input  logic              tm_irq,
    output logic [2:0]        tm_address,
    output logic              tm_chipselect,
    output logic              tm_write_n,
    output logic [15:0]       tm_writedata,
    input  logic [15:0]       tm_readdata,
    output logic [TICK_W-1:0] tick_count,
    output logic              tick_pulse,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic              busy
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WR_PL  = 4'd1,
        S_WR_PH  = 4'd2,
        S_WR_CTL = 4'd3,
        S_RUN    = 4'd4,
        S_ACK    = 4'd5,
        S_ACK_WT = 4'd6,
        S_SN_WR  = 4'd7,
        S_SN_RL  = 4'd8,
        S_SN_RH  = 4'd9,
        S_SN_CAP = 4'd10,
        S_STOP   = 4'd11
    } state_t;

    // Control word fields {STOP, START, CONT, ITO}.
    localparam logic [15:0] CTL_START = {12'h000, 1'b0, 1'b1, CONT, 1'b1};
    localparam logic [15:0] CTL_STOP  = 16'h0008;
    localparam logic [TICK_W-1:0] TICK_ONE = {{(TICK_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic                snap_pending_q, snap_pending_d;
    logic                snap_active_s;
    logic [2:0]          addr_q, addr_d;
    logic                cs_q, cs_d;
    logic                write_n_q, write_n_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [TICK_W-1:0]   tick_count_q, tick_count_d;
    logic                tick_pulse_q, tick_pulse_d;
    logic [31:0]         snap_value_q, snap_value_d;
    logic                snap_valid_q, snap_valid_d;
    logic                busy_q, busy_d;

    // Next-state logic; RUN arbitrates stop > irq service > snapshot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_WR_PL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_PL:  state_d = S_WR_PH;
            S_WR_PH:  state_d = S_WR_CTL;
            S_WR_CTL: state_d = S_RUN;
            S_RUN: begin
                if (!enable) begin
                    state_d = S_STOP;
                end else if (tm_irq) begin
                    state_d = S_ACK;
                end else if (snap_pending_q) begin
                    state_d = S_SN_WR;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_ACK:    state_d = S_ACK_WT;
            S_ACK_WT: state_d = S_RUN;
            S_SN_WR:  state_d = S_SN_RL;
            S_SN_RL:  state_d = S_SN_RH;
            S_SN_RH:  state_d = S_SN_CAP;
            S_SN_CAP: state_d = S_RUN;
            S_STOP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Bus outputs for the cycle the FSM is about to enter; address and data hold when idle.
    always_comb begin
        cs_d      = 1'b0;
        write_n_d = 1'b1;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_d)
            S_WR_PL: begin
                cs_d = 1'b1; write_n_d = 1'b0; addr_d = 3'd2; wdata_d = PERIOD[15:0];
            end
            S_WR_PH: begin
                cs_d = 1'b1; write_n_d = 1'b0; addr_d = 3'd3; wdata_d = PERIOD[31:16];
            end
            S_WR_CTL: begin
                cs_d = 1'b1; write_n_d = 1'b0; addr_d = 3'd1; wdata_d = CTL_START;
            end
            S_ACK: begin
                cs_d = 1'b1; write_n_d = 1'b0; addr_d = 3'd0; wdata_d = 16'h0000;
            end
            S_SN_WR: begin
                cs_d = 1'b1; write_n_d = 1'b0; addr_d = 3'd4; wdata_d = 16'h0000;
            end
            S_SN_RL: begin
                cs_d = 1'b1; write_n_d = 1'b1; addr_d = 3'd4;
            end
            S_SN_RH: begin
                cs_d = 1'b1; write_n_d = 1'b1; addr_d = 3'd5;
            end
            S_STOP: begin
                cs_d = 1'b1; write_n_d = 1'b0; addr_d = 3'd1; wdata_d = CTL_STOP;
            end
            default: begin
                cs_d = 1'b0; write_n_d = 1'b1;
            end
        endcase
        busy_d = !((state_d == S_IDLE) || (state_d == S_RUN));
    end

    assign snap_active_s = (state_q == S_SN_WR) || (state_q == S_SN_RL) ||
                           (state_q == S_SN_RH) || (state_q == S_SN_CAP);

    // Tick counting, snapshot capture and snapshot request bookkeeping.
    always_comb begin
        tick_count_d = tick_count_q;
        tick_pulse_d = 1'b0;
        snap_value_d = snap_value_q;
        snap_valid_d = 1'b0;

        if (state_q == S_ACK) begin
            tick_count_d = tick_count_q + TICK_ONE;
            tick_pulse_d = 1'b1;
        end else begin
            tick_count_d = tick_count_q;
        end

        // Read data lags the address by one cycle, so each half is taken one state late.
        if (state_q == S_SN_RH) begin
            snap_value_d[15:0] = tm_readdata;
        end else if (state_q == S_SN_CAP) begin
            snap_value_d[31:16] = tm_readdata;
            snap_valid_d        = 1'b1;
        end else begin
            snap_value_d = snap_value_q;
        end

        // Requests arriving while a snapshot is in flight merge into that snapshot.
        if ((state_q == S_RUN) && (state_d == S_SN_WR)) begin
            snap_pending_d = 1'b0;
        end else if (snap_req && !snap_active_s) begin
            snap_pending_d = 1'b1;
        end else begin
            snap_pending_d = snap_pending_q;
        end
    end

    // State and snapshot-request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            snap_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            snap_pending_q <= snap_pending_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= 3'd0;
            cs_q         <= 1'b0;
            write_n_q    <= 1'b1;
            wdata_q      <= 16'h0000;
            tick_count_q <= {TICK_W{1'b0}};
            tick_pulse_q <= 1'b0;
            snap_value_q <= 32'h0000_0000;
            snap_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            write_n_q    <= write_n_d;
            wdata_q      <= wdata_d;
            tick_count_q <= tick_count_d;
            tick_pulse_q <= tick_pulse_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign tm_address    = addr_q;
    assign tm_chipselect = cs_q;
    assign tm_write_n    = write_n_q;
    assign tm_writedata  = wdata_q;
    assign tick_count    = tick_count_q;
    assign tick_pulse    = tick_pulse_q;
    assign snap_value    = snap_value_q;
    assign snap_valid    = snap_valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_sys_timer_tick_master.sv
// -----------------------------------------------------------------------------
// Directed testbench for sys_timer_tick_master with a small timer-slave model.
// TICK_W is reduced to 4 so that wrap-around can be reached quickly.
// Inputs are driven and outputs sampled at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sys_timer_tick_master;

    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          snap_req;
    logic          tm_irq;
    logic [2:0]    tm_address;
    logic          tm_chipselect;
    logic          tm_write_n;
    logic [15:0]   tm_writedata;
    logic [15:0]   tm_readdata;
    logic [TW-1:0] tick_count;
    logic          tick_pulse;
    logic [31:0]   snap_value;
    logic          snap_valid;
    logic          busy;

    // Slave model state.
    logic          fire;
    logic          irq_q;
    logic [15:0]   rdata_q;
    logic [31:0]   snap_q;
    int            st_writes;

    int tests = 0;
    int fails = 0;

    logic [20:0] bus_s;
    assign bus_s = {tm_chipselect, tm_write_n, tm_address, tm_writedata};

    sys_timer_tick_master #(
        .PERIOD (32'd49999),
        .CONT   (1'b1),
        .TICK_W (TW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .snap_req      (snap_req),
        .tm_irq        (tm_irq),
        .tm_address    (tm_address),
        .tm_chipselect (tm_chipselect),
        .tm_write_n    (tm_write_n),
        .tm_writedata  (tm_writedata),
        .tm_readdata   (tm_readdata),
        .tick_count    (tick_count),
        .tick_pulse    (tick_pulse),
        .snap_value    (snap_value),
        .snap_valid    (snap_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    assign tm_irq      = irq_q;
    assign tm_readdata = rdata_q;

    // Timer slave: registered read mux, sticky irq cleared by a status write,
    // counter snapshot latched by a write to snapl.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q     <= 1'b0;
            rdata_q   <= 16'h0000;
            snap_q    <= 32'h0000_0000;
            st_writes <= 0;
        end else begin
            case (tm_address)
                3'd4:    rdata_q <= snap_q[15:0];
                3'd5:    rdata_q <= snap_q[31:16];
                default: rdata_q <= 16'hDEAD;
            endcase
            if (tm_chipselect && !tm_write_n && tm_address == 3'd4)
                snap_q <= 32'h0005_1234;
            if (tm_chipselect && !tm_write_n && tm_address == 3'd0) begin
                irq_q     <= 1'b0;
                st_writes <= st_writes + 1;
            end else if (fire) begin
                irq_q <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expects IDLE with enable=1: three consecutive config writes, then RUN.
    task automatic config_seq(input string tag);
        tick();
        chk({tag, "_perl"}, {11'd0, bus_s}, {11'd0, 1'b1, 1'b0, 3'd2, 16'hC34F});
        chk({tag, "_busy1"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, "_perh"}, {11'd0, bus_s}, {11'd0, 1'b1, 1'b0, 3'd3, 16'h0000});
        tick();
        chk({tag, "_ctl"}, {11'd0, bus_s}, {11'd0, 1'b1, 1'b0, 3'd1, 16'h0007});
        tick();
        chk({tag, "_idlebus"}, {11'd0, bus_s}, {11'd0, 1'b0, 1'b1, 3'd1, 16'h0007});
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd0);
    endtask

    // Raises one timeout and waits (bounded) for the matching tick_pulse.
    task automatic service_irq(input string tag);
        logic seen;
        seen = 1'b0;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (tick_pulse) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int pulses, valids, pulse_at, valid_at, ack_at, snwr_at, cs_seen;
        logic found;

        reset_n = 1'b0; enable = 1'b0; snap_req = 1'b0; fire = 1'b0;
        repeat (3) tick();

        // 1: reset values, then configuration
        chk("rst_bus", {11'd0, bus_s}, {11'd0, 1'b0, 1'b1, 3'd0, 16'h0000});
        chk("rst_tick", {28'd0, tick_count}, 32'd0);
        chk("rst_flags", {28'd0, tick_pulse, snap_valid, busy, 1'b0}, 32'd0);
        chk("rst_snap", snap_value, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_hold", {11'd0, bus_s}, {11'd0, 1'b0, 1'b1, 3'd0, 16'h0000});
        enable = 1'b1;
        config_seq("cfg1");

        // 2: single irq service
        base = st_writes;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        tick();
        chk("ack_bus", {11'd0, bus_s}, {11'd0, 1'b1, 1'b0, 3'd0, 16'h0000});
        chk("ack_cnt_pre", {28'd0, tick_count}, 32'd0);
        tick();
        chk("ack_cnt", {28'd0, tick_count}, 32'd1);
        chk("ack_pulse1", {31'd0, tick_pulse}, 32'd1);
        chk("ack_cs0", {31'd0, tm_chipselect}, 32'd0);
        tick();
        chk("ack_pulse0", {31'd0, tick_pulse}, 32'd0);
        chk("ack_busy0", {31'd0, busy}, 32'd0);
        chk("ack_nwr", st_writes - base, 32'd1);
        chk("ack_irqlow", {31'd0, tm_irq}, 32'd0);

        // 3: snapshot
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        tick();
        chk("sn_wr", {11'd0, bus_s}, {11'd0, 1'b1, 1'b0, 3'd4, 16'h0000});
        tick();
        chk("sn_rl", {11'd0, bus_s}, {11'd0, 1'b1, 1'b1, 3'd4, 16'h0000});
        tick();
        chk("sn_rh", {11'd0, bus_s}, {11'd0, 1'b1, 1'b1, 3'd5, 16'h0000});
        tick();
        chk("sn_cap_cs", {30'd0, tm_chipselect, snap_valid}, 32'd0);
        chk("sn_cap_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("sn_value", snap_value, 32'h0005_1234);
        chk("sn_valid1", {31'd0, snap_valid}, 32'd1);
        chk("sn_busy0", {31'd0, busy}, 32'd0);
        tick();
        chk("sn_valid0", {31'd0, snap_valid}, 32'd0);

        // 4: irq and snap_req in the same RUN cycle
        fire = 1'b1;
        tick();
        fire = 1'b0;
        snap_req = 1'b1;
        pulses = 0; valids = 0; pulse_at = -1; valid_at = -1; ack_at = -1; snwr_at = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            snap_req = 1'b0;
            if (tick_pulse) begin pulses++; pulse_at = i; end
            if (snap_valid) begin valids++; valid_at = i; end
            if (tm_chipselect && !tm_write_n && tm_address == 3'd0 && ack_at < 0) ack_at = i;
            if (tm_chipselect && !tm_write_n && tm_address == 3'd4 && snwr_at < 0) snwr_at = i;
        end
        chk("both_pulses", pulses, 32'd1);
        chk("both_valids", valids, 32'd1);
        chk("both_ack_first", {31'd0, (ack_at == 0) && (snwr_at > ack_at)}, 32'd1);
        chk("both_order", {31'd0, (pulse_at >= 0) && (valid_at > pulse_at)}, 32'd1);
        chk("both_cnt", {28'd0, tick_count}, 32'd2);

        // 5: stop and re-enable
        enable = 1'b0;
        tick();
        chk("stop_bus", {11'd0, bus_s}, {11'd0, 1'b1, 1'b0, 3'd1, 16'h0008});
        chk("stop_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("stop_idle", {30'd0, tm_chipselect, busy}, 32'd0);
        cs_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (tm_chipselect) cs_seen++;
        end
        chk("stop_quiet", cs_seen, 32'd0);
        enable = 1'b1;
        config_seq("cfg2");

        // 6: wrap-around of tick_count
        for (int i = 0; i < 13; i++) service_irq("wrap_svc");
        chk("wrap_max", {28'd0, tick_count}, 32'd15);
        service_irq("wrap_svc_last");
        chk("wrap_zero", {28'd0, tick_count}, 32'd0);

        // 6: async reset during SN_RL
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (tm_chipselect && tm_write_n && tm_address == 3'd4) found = 1'b1;
        end
        chk("rst_sn_rl_found", {31'd0, found}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_bus", {11'd0, bus_s}, {11'd0, 1'b0, 1'b1, 3'd0, 16'h0000});
        chk("arst_flags", {28'd0, tick_pulse, snap_valid, busy, 1'b0}, 32'd0);
        chk("arst_snap", snap_value, 32'd0);
        tick();
        tick();
        chk("arst_hold", {30'd0, tm_chipselect, busy}, 32'd0);
        reset_n = 1'b1;
        config_seq("cfg3");
        cs_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (tm_chipselect) cs_seen++;
        end
        chk("arst_no_pending", cs_seen, 32'd0);
        chk("arst_cnt", {28'd0, tick_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
